aes_shift_rows_pipe: RTL and testbench

//  Registered, handshaked (Inv)ShiftRows stage for Rijndael states of 4, 6 or 8 columns.

---
 rtl/aes_pkg.sv | 12 +
 rtl/aes_shift_rows_perm.sv | 19 +
 rtl/aes_shift_rows_pipe.sv | 64 ++++++
 tb/tb_aes_shift_rows_pipe.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared constants and index helpers for the (Inv)ShiftRows stage.
package aes_pkg;
  localparam int NB_MIN = 4;
  localparam int NB_MAX = 8;
  function automatic int sr_offset(input int nb, input int r);
    return (nb == 8 && r >= 2) ? r + 1 : r;
  endfunction
  // LSB position of byte s[r][c]; byte 0 sits in the MSBs, column-major.
  function automatic int sr_idx(input int r, input int c, input int nb);
    return 32 * nb - 8 - 8 * (4 * c + r);
  endfunction
endpackage

// File: rtl/aes_shift_rows_perm.sv
// aes_shift_rows_perm: combinational ShiftRows (inv=0) or InvShiftRows (inv=1) byte permutation.
module aes_shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic              inv,
  input  logic [32*NB-1:0]  istate,
  output logic [32*NB-1:0]  ostate
);
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int FWD = (c + sr_offset(NB, r)) % NB;
      localparam int BWD = (c - sr_offset(NB, r) + NB) % NB;
      assign ostate[sr_idx(r, c, NB) +: 8] = inv ? istate[sr_idx(r, BWD, NB) +: 8]
                                                 : istate[sr_idx(r, FWD, NB) +: 8];
    end
  end
endmodule

// File: rtl/aes_shift_rows_pipe.sv
// aes_shift_rows_pipe: registered, handshaked (Inv)ShiftRows stage for 4/6/8-column states.
// Define AES_SR_FAULT_DETECT_EN to build the inverse-permutation checker driving out_err.
module aes_shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB = 4,
  localparam int W = 32 * NB
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [W-1:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_state,
  output logic         out_err
);
  if (NB < NB_MIN || NB > NB_MAX || NB % 2 != 0) begin : g_bad_nb
    $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
  end
  logic         accept;
  logic [W-1:0] perm_state;
  assign in_ready = ~rst_n | ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  aes_shift_rows_perm #(.NB(NB)) u_perm (
    .inv    (in_inv),
    .istate (in_state),
    .ostate (perm_state)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_state <= '0;
    end else if (flush) out_valid <= 1'b0;
    else if (accept) begin
      out_valid <= 1'b1;
      out_state <= perm_state;
    end else if (out_ready) out_valid <= 1'b0;
`ifdef AES_SR_FAULT_DETECT_EN
  logic [W-1:0] copy_state;
  logic         copy_inv;
  logic [W-1:0] chk_state;
  // Undo the permutation on the held result; it must reproduce the captured input.
  aes_shift_rows_perm #(.NB(NB)) u_chk (
    .inv    (~copy_inv),
    .istate (out_state),
    .ostate (chk_state)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      copy_state <= '0;
      copy_inv   <= 1'b0;
    end else if (accept && !flush) begin
      copy_state <= in_state;
      copy_inv   <= in_inv;
    end
  assign out_err = out_valid & (chk_state != copy_state);
`else
  assign out_err = 1'b0;
`endif
endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// tb_aes_shift_rows_pipe: vector table plus scoreboard bench for aes_shift_rows_pipe (NB=4 and NB=8).
module tb_aes_shift_rows_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, flush;
  logic iv, ir4, inv, ov4, ordy, oe4;
  logic [127:0] is4, os4;
  logic v8, ir8, inv8, ov8, oe8;
  logic [255:0] is8, os8;
  aes_shift_rows_pipe #(.NB(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv), .in_ready(ir4), .in_inv(inv),
    .in_state(is4), .out_valid(ov4), .out_ready(ordy), .out_state(os4), .out_err(oe4)
  );
  aes_shift_rows_pipe #(.NB(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(v8), .in_ready(ir8), .in_inv(inv8),
    .in_state(is8), .out_valid(ov8), .out_ready(1'b1), .out_state(os8), .out_err(oe8)
  );
  int nchk = 0, nfail = 0, n_out = 0;
  logic [127:0] q[$];
  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  function automatic logic [255:0] model(input int nb, input logic dir, input logic [255:0] s);
    logic [255:0] o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++) begin
        int off = (nb == 8 && r > 1) ? r + 1 : r;
        int src = dir ? (c - off + nb) % nb : (c + off) % nb;
        o[nb*32-8-8*(4*c+r) +: 8] = s[nb*32-8-8*(4*src+r) +: 8];
      end
    return o;
  endfunction
  always @(negedge clk)
    if (!rst_n) q.delete();
    else begin
      if (ov4 && ordy) begin
        n_out++;
        check("sb_err", {255'b0, oe4}, 256'b0);
        if (q.size() == 0) check("sb_unexpected_output", 256'd1, 256'd0);
        else check("sb_data", {128'b0, os4}, {128'b0, q.pop_front()});
      end else if (flush && ov4 && q.size() != 0) void'(q.pop_front());
      if (iv && ir4 && !flush) begin
        logic [255:0] t;
        t = model(4, inv, {128'b0, is4});
        q.push_back(t[127:0]);
      end
    end
  typedef struct {
    logic         dir;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;
  vec_t tab[4];
  logic [127:0] e0, rnd;
  logic [255:0] t8, src8, r8;
  int n0;
  initial begin
    rst_n = 0; flush = 0; iv = 0; inv = 0; is4 = '0; ordy = 1;
    v8 = 0; inv8 = 0; is8 = '0;
    tab[0] = '{1'b0, 128'h000102030405060708090a0b0c0d0e0f, 128'h00050a0f04090e03080d02070c01060b};
    tab[1] = '{1'b1, 128'h00050a0f04090e03080d02070c01060b, 128'h000102030405060708090a0b0c0d0e0f};
    for (int i = 2; i < 4; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      t8 = model(4, i[0], {128'b0, rnd});
      tab[i] = '{i[0], rnd, t8[127:0]};
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {255'b0, ov4}, 256'b0);
    check("reset_out_state", {128'b0, os4}, 256'b0);
    check("reset_in_ready", {255'b0, ir4}, 256'd1);
    check("reset_out_valid8", {255'b0, ov8}, 256'b0);
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      iv = 1; inv = tab[i].dir; is4 = tab[i].din;
      @(posedge clk); #1;
      check("vec_valid", {255'b0, ov4}, 256'd1);
      check($sformatf("vec%0d_data", i), {128'b0, os4}, {128'b0, tab[i].dout});
    end
    iv = 0;
    @(posedge clk); #1;
    // NB=8 forward then inverse round trip
    for (int i = 0; i < 32; i++) src8[255-8*i -: 8] = 8'(i);
    v8 = 1; inv8 = 0; is8 = src8;
    @(posedge clk); #1;
    t8 = model(8, 1'b0, src8);
    check("nb8_valid", {255'b0, ov8}, 256'd1);
    check("nb8_col0", {224'b0, os8[255 -: 32]}, {224'b0, 32'h00050e13});
    check("nb8_fwd", os8, t8);
    r8 = os8; inv8 = 1; is8 = r8;
    @(posedge clk); #1;
    check("nb8_roundtrip", os8, src8);
    v8 = 0;
    @(posedge clk); #1;
    // back-to-back with two stall cycles
    n0 = n_out;
    iv = 1; inv = 0; is4 = {$urandom, $urandom, $urandom, $urandom}; ordy = 1;
    t8 = model(4, 1'b0, {128'b0, is4}); e0 = t8[127:0];
    @(posedge clk); #1;
    is4 = {$urandom, $urandom, $urandom, $urandom}; inv = 1; ordy = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("stall_in_ready", {255'b0, ir4}, 256'b0);
      check("stall_valid", {255'b0, ov4}, 256'd1);
      check("stall_data", {128'b0, os4}, {128'b0, e0});
      @(posedge clk); #1;
    end
    ordy = 1;
    @(posedge clk); #1;
    is4 = {$urandom, $urandom, $urandom, $urandom}; inv = 0;
    @(posedge clk); #1;
    iv = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("b2b_count", 256'(n_out - n0), 256'd3);
    check("b2b_queue_empty", 256'(q.size()), 256'd0);
    // flush of held entry, then flush discarding an accept
    n0 = n_out;
    iv = 1; is4 = {$urandom, $urandom, $urandom, $urandom}; ordy = 0;
    @(posedge clk); #1;
    flush = 1; is4 = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    check("flush_valid", {255'b0, ov4}, 256'b0);
    ordy = 1;
    @(posedge clk); #1;
    check("flush_discard_valid", {255'b0, ov4}, 256'b0);
    flush = 0; iv = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("flush_no_output", 256'(n_out - n0), 256'd0);
    check("flush_queue_empty", 256'(q.size()), 256'd0);
    // reset while stalled
    @(posedge clk); #1;
    iv = 1; is4 = {$urandom, $urandom, $urandom, $urandom}; ordy = 0;
    @(posedge clk); #1;
    iv = 0; rst_n = 0;
    @(negedge clk);
    check("rst_in_ready", {255'b0, ir4}, 256'd1);
    @(posedge clk); #1;
    rst_n = 1;
    check("rst_valid", {255'b0, ov4}, 256'b0);
    check("rst_state", {128'b0, os4}, 256'b0);
    check("rst_ready_after", {255'b0, ir4}, 256'd1);
    iv = 1; inv = tab[0].dir; is4 = tab[0].din; ordy = 1;
    @(posedge clk); #1;
    iv = 0;
    check("post_rst_valid", {255'b0, ov4}, 256'd1);
    check("post_rst_data", {128'b0, os4}, {128'b0, tab[0].dout});
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("final_queue_empty", 256'(q.size()), 256'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
